// File: rtl/riscv_debug_cmd_pkg.sv
// Shared types and constants for the debug command sequencer.
// Contents:
//    seq_state_t     - sequencer FSM states
//    DBG_OP_READ     - dbg_op encoding for a single-word read
//    DBG_OP_WRITE    - dbg_op encoding for a single-word write
//    DBG_DATA_IS_REG - bit of dbg_data that selects GPR (1) vs CSR (0)
//    next_addr()     - address step between words of a multi-word command
package riscv_debug_cmd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_WDATA = 2'd1,
      ST_WAIT_SPACE = 2'd2,
      ST_ISSUE      = 2'd3
   } seq_state_t;

   localparam logic [1:0] DBG_OP_READ     = 2'h0;
   localparam logic [1:0] DBG_OP_WRITE    = 2'h1;
   localparam int         DBG_DATA_IS_REG = 12;

   // GPR addresses wrap inside the 32-entry register file and keep the
   // upper bits clear; CSR addresses wrap over the full 12-bit space.
   function automatic logic [11:0] next_addr(input logic        is_reg,
                                             input logic [11:0] addr,
                                             input logic        autoinc);
      logic [11:0] n;
      n = addr;
      if (autoinc) begin
         if (is_reg) begin
            n = {7'd0, addr[4:0] + 5'd1};
         end else begin
            n = addr + 12'd1;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/riscv_debug_rdata_fifo.sv
// Read-data FIFO for the debug command sequencer.
// Ports:
//    i_clk, i_reset   - clock, asynchronous active-high reset (empties FIFO)
//    i_push, i_wdata  - write one word (ignored when full unless popping too)
//    i_pop            - remove head word (ignored when empty)
//    o_rdata          - head word, zero while empty
//    o_full, o_empty  - occupancy flags
module riscv_debug_rdata_fifo #(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_push,
   input  logic [31:0] i_wdata,
   input  logic        i_pop,
   output logic [31:0] o_rdata,
   output logic        o_full,
   output logic        o_empty
);

   logic [31:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign w_pop   = i_pop && !o_empty;
   // A push into a full FIFO is legal when the head leaves in the same cycle.
   assign w_push  = i_push && (!o_full || w_pop);
   assign o_rdata = o_empty ? 32'd0 : r_mem[r_rd_ptr];

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: the head is masked to zero while empty.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/riscv_i32_debug_cmd_sequencer.sv
// Debug command sequencer: expands one abstract multi-word GPR/CSR command
// into single-word ops on the per-hart debug interface.
// Ports:
//    i_clk, i_reset                   - clock, async active-high reset
//    i_cmd_* / o_cmd_ready            - host command (count = words - 1)
//    i_wdata_valid/i_wdata/o_wdata_ready - streamed write words
//    o_dbg_valid/o_dbg_op/o_dbg_data/o_dbg_wdata - one-hot per-hart op request
//    i_dbg_ack/i_dbg_rdata/i_dbg_error - op completion from the target hart
//    o_rdata_valid/o_rdata/i_rdata_ready - read-result FIFO head
//    o_busy, o_error, i_clear_error   - status, sticky error and its clear
module riscv_i32_debug_cmd_sequencer
   import riscv_debug_cmd_pkg::*;
#(
   parameter  int NUM_HARTS   = 1,
   parameter  int COUNT_W     = 4,
   parameter  int RDATA_DEPTH = 4,
   localparam int HW          = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_cmd_valid,
   output logic                 o_cmd_ready,
   input  logic                 i_cmd_write,
   input  logic                 i_cmd_is_reg,
   input  logic [11:0]          i_cmd_addr,
   input  logic [COUNT_W-1:0]   i_cmd_count,
   input  logic                 i_cmd_autoinc,
   input  logic [HW-1:0]        i_cmd_hart,
   input  logic                 i_wdata_valid,
   output logic                 o_wdata_ready,
   input  logic [31:0]          i_wdata,
   output logic [NUM_HARTS-1:0] o_dbg_valid,
   output logic [1:0]           o_dbg_op,
   output logic [15:0]          o_dbg_data,
   output logic [31:0]          o_dbg_wdata,
   input  logic [NUM_HARTS-1:0] i_dbg_ack,
   input  logic [31:0]          i_dbg_rdata,
   input  logic                 i_dbg_error,
   output logic                 o_rdata_valid,
   input  logic                 i_rdata_ready,
   output logic [31:0]          o_rdata,
   output logic                 o_busy,
   output logic                 o_error,
   input  logic                 i_clear_error
);

   seq_state_t           r_state;
   logic                 r_write;
   logic                 r_is_reg;
   logic                 r_autoinc;
   logic                 r_error;
   logic [11:0]          r_addr;
   logic [COUNT_W-1:0]   r_remaining;
   logic [HW-1:0]        r_hart;
   logic [NUM_HARTS-1:0] r_dbg_valid;
   logic [31:0]          r_dbg_wdata;

   logic                 w_cmd_fire;
   logic                 w_hart_ok;
   logic                 w_ack;
   logic                 w_push;
   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic                 w_space;
   logic [NUM_HARTS-1:0] w_hart_onehot;
   logic [15:0]          w_dbg_data;

   assign o_cmd_ready   = (r_state == ST_IDLE) && !r_error;
   assign o_wdata_ready = (r_state == ST_WAIT_WDATA);
   assign o_busy        = (r_state != ST_IDLE);
   assign o_error       = r_error;
   assign o_dbg_valid   = r_dbg_valid;
   assign o_dbg_op      = r_write ? DBG_OP_WRITE : DBG_OP_READ;
   assign o_dbg_wdata   = r_dbg_wdata;
   assign o_dbg_data    = w_dbg_data;
   assign o_rdata_valid = !w_fifo_empty;

   assign w_cmd_fire    = i_cmd_valid && o_cmd_ready;
   assign w_hart_ok     = (32'(i_cmd_hart) < NUM_HARTS);
   assign w_hart_onehot = NUM_HARTS'(1) << r_hart;
   // r_dbg_valid is only non-zero in ISSUE, so acks from other harts are masked.
   assign w_ack         = |(i_dbg_ack & r_dbg_valid);
   // Free slot now, or one freed by a pop in this same cycle.
   assign w_space       = !w_fifo_full || (i_rdata_ready && !w_fifo_empty);
   // Reads push their result even when the hart flags an error.
   assign w_push        = (r_state == ST_ISSUE) && w_ack && !r_write;

   always_comb begin
      w_dbg_data                  = '0;
      w_dbg_data[11:0]            = r_addr;
      w_dbg_data[DBG_DATA_IS_REG] = r_is_reg;
   end

   // Command FSM. dbg_valid is raised on entry to ISSUE and dropped on the
   // ack edge, so it never depends combinationally on dbg_ack.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_write     <= 1'b0;
         r_is_reg    <= 1'b0;
         r_autoinc   <= 1'b0;
         r_error     <= 1'b0;
         r_addr      <= '0;
         r_remaining <= '0;
         r_hart      <= '0;
         r_dbg_valid <= '0;
         r_dbg_wdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_clear_error) r_error <= 1'b0;
               if (w_cmd_fire) begin
                  r_write     <= i_cmd_write;
                  r_is_reg    <= i_cmd_is_reg;
                  r_addr      <= i_cmd_is_reg ? {7'd0, i_cmd_addr[4:0]} : i_cmd_addr;
                  r_autoinc   <= i_cmd_autoinc;
                  r_hart      <= i_cmd_hart;
                  r_remaining <= i_cmd_count;
                  if (!w_hart_ok) begin
                     r_error <= 1'b1;
                  end else begin
                     r_state <= i_cmd_write ? ST_WAIT_WDATA : ST_WAIT_SPACE;
                  end
               end
            end
            ST_WAIT_WDATA: begin
               if (i_wdata_valid) begin
                  r_dbg_wdata <= i_wdata;
                  r_dbg_valid <= w_hart_onehot;
                  r_state     <= ST_ISSUE;
               end
            end
            ST_WAIT_SPACE: begin
               if (w_space) begin
                  r_dbg_valid <= w_hart_onehot;
                  r_state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (w_ack) begin
                  r_dbg_valid <= '0;
                  if (i_dbg_error) begin
                     r_error <= 1'b1;
                     r_state <= ST_IDLE;
                  end else if (r_remaining == '0) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_remaining <= r_remaining - COUNT_W'(1);
                     r_addr      <= next_addr(r_is_reg, r_addr, r_autoinc);
                     r_state     <= r_write ? ST_WAIT_WDATA : ST_WAIT_SPACE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   riscv_debug_rdata_fifo #(
      .DEPTH (RDATA_DEPTH)
   ) u_rdata_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (w_push),
      .i_wdata (i_dbg_rdata),
      .i_pop   (i_rdata_ready),
      .o_rdata (o_rdata),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

endmodule

// File: tb/tb_riscv_i32_debug_cmd_sequencer.sv
// Testbench for riscv_i32_debug_cmd_sequencer with three harts.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_riscv_i32_debug_cmd_sequencer;

   localparam int NUM_HARTS   = 3;
   localparam int COUNT_W     = 4;
   localparam int RDATA_DEPTH = 4;
   localparam int HW          = 2;

   logic                 clock = 1'b0;
   logic                 reset;
   logic                 cmdValid, cmdReady, cmdWrite, cmdIsReg, cmdAutoinc;
   logic [11:0]          cmdAddr;
   logic [COUNT_W-1:0]   cmdCount;
   logic [HW-1:0]        cmdHart;
   logic                 wdataValid, wdataReady;
   logic [31:0]          wdata;
   logic [NUM_HARTS-1:0] dbgValid, dbgAck;
   logic [1:0]           dbgOp;
   logic [15:0]          dbgData;
   logic [31:0]          dbgWdata, dbgRdata;
   logic                 dbgError;
   logic                 rdataValid, rdataReady;
   logic [31:0]          rdata;
   logic                 busy, error, clearError;

   int          checkCount = 0;
   int          passCount  = 0;
   logic [31:0] modelFifo[$];
   bit          modelError = 0;

   riscv_i32_debug_cmd_sequencer #(
      .NUM_HARTS   (NUM_HARTS),
      .COUNT_W     (COUNT_W),
      .RDATA_DEPTH (RDATA_DEPTH)
   ) dut (
      .i_clk         (clock),
      .i_reset       (reset),
      .i_cmd_valid   (cmdValid),
      .o_cmd_ready   (cmdReady),
      .i_cmd_write   (cmdWrite),
      .i_cmd_is_reg  (cmdIsReg),
      .i_cmd_addr    (cmdAddr),
      .i_cmd_count   (cmdCount),
      .i_cmd_autoinc (cmdAutoinc),
      .i_cmd_hart    (cmdHart),
      .i_wdata_valid (wdataValid),
      .o_wdata_ready (wdataReady),
      .i_wdata       (wdata),
      .o_dbg_valid   (dbgValid),
      .o_dbg_op      (dbgOp),
      .o_dbg_data    (dbgData),
      .o_dbg_wdata   (dbgWdata),
      .i_dbg_ack     (dbgAck),
      .i_dbg_rdata   (dbgRdata),
      .i_dbg_error   (dbgError),
      .o_rdata_valid (rdataValid),
      .i_rdata_ready (rdataReady),
      .o_rdata       (rdata),
      .o_busy        (busy),
      .o_error       (error),
      .i_clear_error (clearError)
   );

   // 100 MHz free-running clock.
   always #5 clock = ~clock;

   // Hard stop in case a bounded wait was somehow bypassed.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
   endtask

   // Pop one word and compare it with the oldest word the model expects.
   task automatic popOne();
      logic [31:0] expWord;
      checkOutput("rdata_valid", 32'(rdataValid), 32'd1);
      if (modelFifo.size() > 0) begin
         expWord = modelFifo.pop_front();
         checkOutput("rdata", rdata, expWord);
      end
      rdataReady = 1'b1;
      @(negedge clock);
      rdataReady = 1'b0;
   endtask

   task automatic drainFifo();
      while (modelFifo.size() > 0) popOne();
      checkOutput("fifo_empty", 32'(rdataValid), 32'd0);
   endtask

   task automatic doClearError();
      clearError = 1'b1;
      @(negedge clock);
      clearError = 1'b0;
      modelError = 1'b0;
      checkOutput("error_cleared", 32'(error), 32'd0);
      checkOutput("cmd_ready_after_clear", 32'(cmdReady), 32'd1);
   endtask

   // Issue one command and play the hart side of every word it produces.
   // errWord selects the word whose ack reports an error (-1 for none).
   task automatic applyStimulus(input bit write, input bit isReg, input logic [11:0] addr,
                                input int count, input bit autoinc, input int hart,
                                input int errWord);
      int          t;
      int          nHold;
      int          baseAddr;
      int          expAddr;
      logic [31:0] wordW;
      logic [31:0] wordR;
      logic [NUM_HARTS-1:0] oneHot;

      checkOutput("cmd_ready", 32'(cmdReady), 32'(!modelError));
      cmdValid   = 1'b1;
      cmdWrite   = write;
      cmdIsReg   = isReg;
      cmdAddr    = addr;
      cmdCount   = COUNT_W'(count);
      cmdAutoinc = autoinc;
      cmdHart    = HW'(hart);
      @(negedge clock);
      cmdValid = 1'b0;

      if (hart >= NUM_HARTS) begin
         modelError = 1'b1;
         checkOutput("bad_hart_error", 32'(error), 32'd1);
         checkOutput("bad_hart_busy", 32'(busy), 32'd0);
         repeat (2) begin
            @(negedge clock);
            checkOutput("bad_hart_no_op", 32'(dbgValid), 32'd0);
         end
         return;
      end

      oneHot   = NUM_HARTS'(1 << hart);
      baseAddr = isReg ? (int'(addr) % 32) : int'(addr);
      for (int k = 0; k <= count; k++) begin
         if (!autoinc) expAddr = baseAddr;
         else if (isReg) expAddr = (baseAddr + k) % 32;
         else expAddr = (baseAddr + k) % 4096;

         if (write) begin
            wordW = $urandom;
            t = 0;
            while (!wdataReady && t < 20) begin
               @(negedge clock);
               t++;
            end
            checkOutput("wdata_ready", 32'(wdataReady), 32'd1);
            wdataValid = 1'b1;
            wdata      = wordW;
            @(negedge clock);
            wdataValid = 1'b0;
         end else if (modelFifo.size() == RDATA_DEPTH) begin
            // No room for the result: the op must wait until a word leaves.
            repeat (3) @(negedge clock);
            checkOutput("stall_no_op", 32'(dbgValid), 32'd0);
            checkOutput("stall_busy", 32'(busy), 32'd1);
            popOne();
         end

         t = 0;
         while (dbgValid == '0 && t < 20) begin
            @(negedge clock);
            t++;
         end
         checkOutput("dbg_valid", 32'(dbgValid), 32'(oneHot));
         checkOutput("dbg_op", 32'(dbgOp), write ? 32'd1 : 32'd0);
         checkOutput("dbg_data", 32'(dbgData), 32'((int'(isReg) << 12) | expAddr));
         if (write) checkOutput("dbg_wdata", dbgWdata, wordW);

         // Acks from the other harts must not complete the op.
         nHold = $urandom_range(1, 2);
         for (int h = 0; h < nHold; h++) begin
            dbgAck   = ~oneHot;
            dbgError = 1'b1;
            @(negedge clock);
            checkOutput("hold_dbg_valid", 32'(dbgValid), 32'(oneHot));
         end

         wordR    = $urandom;
         dbgAck   = oneHot;
         dbgRdata = wordR;
         dbgError = (k == errWord);
         @(negedge clock);
         dbgAck   = '0;
         dbgError = 1'b0;
         checkOutput("dbg_valid_drop", 32'(dbgValid), 32'd0);
         if (!write) modelFifo.push_back(wordR);
         if (k == errWord) begin
            modelError = 1'b1;
            break;
         end
      end

      t = 0;
      while (busy && t < 20) begin
         @(negedge clock);
         t++;
      end
      checkOutput("busy_done", 32'(busy), 32'd0);
      checkOutput("error_state", 32'(error), 32'(modelError));
   endtask

   initial begin
      int cnt, hart, errWord;

      reset      = 1'b1;
      cmdValid   = 1'b0;
      cmdWrite   = 1'b0;
      cmdIsReg   = 1'b0;
      cmdAddr    = '0;
      cmdCount   = '0;
      cmdAutoinc = 1'b0;
      cmdHart    = '0;
      wdataValid = 1'b0;
      wdata      = '0;
      dbgAck     = '0;
      dbgRdata   = '0;
      dbgError   = 1'b0;
      rdataReady = 1'b0;
      clearError = 1'b0;

      #1;
      checkOutput("rst_cmd_ready", 32'(cmdReady), 32'd1);
      checkOutput("rst_wdata_ready", 32'(wdataReady), 32'd0);
      checkOutput("rst_dbg_valid", 32'(dbgValid), 32'd0);
      checkOutput("rst_dbg_data", 32'(dbgData), 32'd0);
      checkOutput("rst_rdata_valid", 32'(rdataValid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_error", 32'(error), 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      // Single GPR read, then a three-word autoincrement CSR write.
      applyStimulus(1'b0, 1'b1, 12'd5, 0, 1'b0, 0, -1);
      drainFifo();
      applyStimulus(1'b1, 1'b0, 12'h300, 2, 1'b1, 0, -1);

      // GPR wrap from x30 filling the FIFO, then a read that must stall.
      applyStimulus(1'b0, 1'b1, 12'd30, 3, 1'b1, 0, -1);
      checkOutput("fifo_full_valid", 32'(rdataValid), 32'd1);
      applyStimulus(1'b0, 1'b1, 12'd2, 0, 1'b0, 2, -1);
      drainFifo();

      // Non-zero hart, then an out-of-range hart.
      applyStimulus(1'b0, 1'b0, 12'h7C0, 0, 1'b0, 1, -1);
      drainFifo();
      applyStimulus(1'b0, 1'b1, 12'd1, 0, 1'b0, 3, -1);
      @(negedge clock);
      checkOutput("sticky_cmd_ready", 32'(cmdReady), 32'(!modelError));
      doClearError();

      // Error on the second word of a four-word read.
      applyStimulus(1'b0, 1'b1, 12'd10, 3, 1'b1, 1, 1);
      @(negedge clock);
      checkOutput("err_cmd_ready", 32'(cmdReady), 32'(!modelError));
      checkOutput("err_sticky", 32'(error), 32'(modelError));
      drainFifo();
      doClearError();

      // Randomised commands; the FIFO is drained only sometimes.
      for (int n = 0; n < 40; n++) begin
         cnt     = $urandom_range(0, 5);
         hart    = $urandom_range(0, 3);
         errWord = ($urandom_range(0, 7) == 0) ? $urandom_range(0, cnt) : -1;
         applyStimulus(1'($urandom), 1'($urandom), 12'($urandom), cnt,
                       1'($urandom), hart, errWord);
         if (modelError) doClearError();
         if ($urandom_range(0, 1) == 1) drainFifo();
      end
      drainFifo();

      // Reset in the middle of a write op with a word left in the FIFO.
      applyStimulus(1'b0, 1'b1, 12'd7, 0, 1'b0, 0, -1);
      cmdValid   = 1'b1;
      cmdWrite   = 1'b1;
      cmdIsReg   = 1'b0;
      cmdAddr    = 12'h341;
      cmdCount   = COUNT_W'(1);
      cmdAutoinc = 1'b0;
      cmdHart    = HW'(2);
      @(negedge clock);
      cmdValid   = 1'b0;
      wdataValid = 1'b1;
      wdata      = 32'hDEAD_BEEF;
      @(negedge clock);
      wdataValid = 1'b0;
      checkOutput("pre_reset_valid", 32'(dbgValid), 32'd4);
      #2 reset = 1'b1;
      #1;
      modelFifo.delete();
      modelError = 1'b0;
      checkOutput("mid_rst_dbg_valid", 32'(dbgValid), 32'd0);
      checkOutput("mid_rst_dbg_op", 32'(dbgOp), 32'd0);
      checkOutput("mid_rst_dbg_data", 32'(dbgData), 32'd0);
      checkOutput("mid_rst_dbg_wdata", dbgWdata, 32'd0);
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      checkOutput("mid_rst_cmd_ready", 32'(cmdReady), 32'd1);
      checkOutput("mid_rst_rdata_valid", 32'(rdataValid), 32'd0);
      checkOutput("mid_rst_rdata", rdata, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      applyStimulus(1'b0, 1'b0, 12'hFFF, 1, 1'b1, 1, -1);
      drainFifo();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
